// File: rtl/lsu_pe_tcdm_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pe_tcdm_if
// Description : TCDM request/grant/response bundle between the PE load/store
//               unit (master) and the memory side (slave).
//               Request side  : data_req_o, data_add_o, data_wen_o,
//                               data_wdata_o, data_be_o
//               Response side : data_gnt_i, data_r_valid_i, data_r_rdata_i
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_pe_tcdm_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
);
    logic              data_req_o;
    logic [AWIDTH-1:0] data_add_o;
    logic              data_wen_o;
    logic [DWIDTH-1:0] data_wdata_o;
    logic [3:0]        data_be_o;
    logic              data_gnt_i;
    logic              data_r_valid_i;
    logic [DWIDTH-1:0] data_r_rdata_i;

    modport master (
        output data_req_o,
        output data_add_o,
        output data_wen_o,
        output data_wdata_o,
        output data_be_o,
        input  data_gnt_i,
        input  data_r_valid_i,
        input  data_r_rdata_i
    );

    modport slave (
        input  data_req_o,
        input  data_add_o,
        input  data_wen_o,
        input  data_wdata_o,
        input  data_be_o,
        output data_gnt_i,
        output data_r_valid_i,
        output data_r_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/lsu_pe_tcdm.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pe_tcdm
// Description : Load/store unit for one CGRA processing element. Issues a
//               single-outstanding TCDM req/gnt/r_valid transaction for load
//               (5'b00111) and store (5'b01000) opcodes and returns load data
//               with a one-cycle valid pulse.
// Ports       : Clk, Reset (async, active-low)
//               Exec_En_Global, LSU_En, Opcode, Addr_In, Store_Data_In - PE side
//               tcdm           - TCDM bus (master modport)
//               load_data_o / data_req_valid_o - load result and its pulse
//               lsu_busy_o     - transaction in flight
//               protocol_err_o - sticky flag for an unexpected r_valid
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_pe_tcdm #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  wire logic              Clk,
    input  wire logic              Reset,
    input  wire logic              Exec_En_Global,
    input  wire logic              LSU_En,
    input  wire logic [4:0]        Opcode,
    input  wire logic [AWIDTH-1:0] Addr_In,
    input  wire logic [DWIDTH-1:0] Store_Data_In,
    lsu_pe_tcdm_if.master          tcdm,
    output logic      [DWIDTH-1:0] load_data_o,
    output logic                   data_req_valid_o,
    output logic                   lsu_busy_o,
    output logic                   protocol_err_o
);

    localparam logic [4:0] OP_LOAD  = 5'b00111;
    localparam logic [4:0] OP_STORE = 5'b01000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] add_q, add_d;
    logic              wen_q, wen_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] load_data_q, load_data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic is_load, is_store, start;

    // Byte-offset bits are dropped by word alignment.
    logic unused_addr_bits;
    assign unused_addr_bits = ^Addr_In[1:0];

    assign is_load  = (Opcode == OP_LOAD);
    assign is_store = (Opcode == OP_STORE);
    assign start    = (state_q == ST_IDLE) && Exec_En_Global && LSU_En
                      && (is_load || is_store);

    always_comb begin
        state_d     = state_q;
        add_d       = add_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        valid_d     = 1'b0;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_REQ;
                    add_d   = {Addr_In[AWIDTH-1:2], 2'b00};
                    wen_d   = is_load;
                    if (is_store) begin
                        wdata_d = Store_Data_In;
                    end
                end
            end
            ST_REQ: begin
                // Address/wen/wdata stay frozen until the grant arrives.
                if (tcdm.data_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tcdm.data_r_valid_i) begin
                    state_d = ST_IDLE;
                    if (wen_q) begin
                        load_data_d = tcdm.data_r_rdata_i;
                        valid_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A response is only legal while waiting for one; anything else is
        // a bus protocol violation that stays flagged until reset.
        if (tcdm.data_r_valid_i && (state_q != ST_WAIT)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            add_q       <= '0;
            wen_q       <= 1'b1;
            wdata_q     <= '0;
            load_data_q <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            add_q       <= add_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    // Request is decoded from registered state only, never from inputs.
    assign tcdm.data_req_o   = (state_q == ST_REQ);
    assign tcdm.data_add_o   = add_q;
    assign tcdm.data_wen_o   = wen_q;
    assign tcdm.data_wdata_o = wdata_q;
    assign tcdm.data_be_o    = 4'hF;

    assign load_data_o      = load_data_q;
    assign data_req_valid_o = valid_q;
    assign lsu_busy_o       = (state_q != ST_IDLE);
    assign protocol_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_pe_tcdm.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_pe_tcdm
// Description : Directed testbench for lsu_pe_tcdm with a load-data
//               scoreboard; expected load words are queued when the load is
//               issued and popped when the DUT pulses data_req_valid_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_pe_tcdm;

    localparam int DWIDTH = 32;
    localparam int AWIDTH = 32;

    logic              Clk;
    logic              Reset;
    logic              Exec_En_Global;
    logic              LSU_En;
    logic [4:0]        Opcode;
    logic [AWIDTH-1:0] Addr_In;
    logic [DWIDTH-1:0] Store_Data_In;
    logic [DWIDTH-1:0] load_data_o;
    logic              data_req_valid_o;
    logic              lsu_busy_o;
    logic              protocol_err_o;

    lsu_pe_tcdm_if #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) tcdm ();

    lsu_pe_tcdm #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Exec_En_Global   (Exec_En_Global),
        .LSU_En           (LSU_En),
        .Opcode           (Opcode),
        .Addr_In          (Addr_In),
        .Store_Data_In    (Store_Data_In),
        .tcdm             (tcdm),
        .load_data_o      (load_data_o),
        .data_req_valid_o (data_req_valid_o),
        .lsu_busy_o       (lsu_busy_o),
        .protocol_err_o   (protocol_err_o)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int vectors     = 0;
    int miscompares = 0;
    logic [DWIDTH-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: returns 1 time unit after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [AWIDTH-1:0] a,
                         input logic [DWIDTH-1:0] sd);
        LSU_En        = 1'b1;
        Opcode        = op;
        Addr_In       = a;
        Store_Data_In = sd;
    endtask

    // Zero-wait load: start, gnt one cycle later, r_valid one cycle after.
    task automatic do_load(input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] rd);
        exp_q.push_back(rd);
        issue(5'b00111, a, '0);
        step();
        chk("ld_req", tcdm.data_req_o, 1);
        LSU_En = 1'b0;
        tcdm.data_gnt_i = 1'b1;
        step();
        tcdm.data_gnt_i      = 1'b0;
        tcdm.data_r_valid_i  = 1'b1;
        tcdm.data_r_rdata_i  = rd;
        step();
        tcdm.data_r_valid_i  = 1'b0;
        chk("ld_pulse", data_req_valid_o, 1);
    endtask

    // Scoreboard: every valid pulse must match the oldest outstanding load.
    always @(posedge Clk) begin
        #1;
        if (data_req_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pulse", data_req_valid_o, 0);
            end else begin
                chk("sb_load_data", load_data_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        Reset               = 1'b0;
        Exec_En_Global      = 1'b1;
        LSU_En              = 1'b0;
        Opcode              = 5'b0;
        Addr_In             = '0;
        Store_Data_In       = '0;
        tcdm.data_gnt_i     = 1'b0;
        tcdm.data_r_valid_i = 1'b0;
        tcdm.data_r_rdata_i = '0;
        #22;
        Reset = 1'b1;
        step();

        // Reset values
        chk("rst_req",   tcdm.data_req_o, 0);
        chk("rst_add",   tcdm.data_add_o, 0);
        chk("rst_wdata", tcdm.data_wdata_o, 0);
        chk("rst_wen",   tcdm.data_wen_o, 1);
        chk("rst_be",    tcdm.data_be_o, 4'hF);
        chk("rst_ld",    load_data_o, 0);
        chk("rst_vld",   data_req_valid_o, 0);
        chk("rst_busy",  lsu_busy_o, 0);
        chk("rst_err",   protocol_err_o, 0);

        // Load, zero-wait
        exp_q.push_back(32'hDEAD_BEEF);
        issue(5'b00111, 32'h1000_0006, '0);
        step();
        chk("l1_req",  tcdm.data_req_o, 1);
        chk("l1_add",  tcdm.data_add_o, 32'h1000_0004);
        chk("l1_wen",  tcdm.data_wen_o, 1);
        chk("l1_busy", lsu_busy_o, 1);
        LSU_En = 1'b0;
        tcdm.data_gnt_i = 1'b1;
        step();
        chk("l1_req_drop", tcdm.data_req_o, 0);
        chk("l1_no_early_pulse", data_req_valid_o, 0);
        tcdm.data_gnt_i     = 1'b0;
        tcdm.data_r_valid_i = 1'b1;
        tcdm.data_r_rdata_i = 32'hDEAD_BEEF;
        step();
        tcdm.data_r_valid_i = 1'b0;
        chk("l1_pulse", data_req_valid_o, 1);
        chk("l1_data",  load_data_o, 32'hDEAD_BEEF);
        chk("l1_idle",  lsu_busy_o, 0);
        step();
        chk("l1_pulse_one_cycle", data_req_valid_o, 0);

        // Store with grant stall; PE op attempted during REQ must be ignored
        issue(5'b01000, 32'h2000_0001, 32'h0000_00A5);
        step();
        issue(5'b00111, 32'h3000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            chk("st_req",   tcdm.data_req_o, 1);
            chk("st_add",   tcdm.data_add_o, 32'h2000_0000);
            chk("st_wdata", tcdm.data_wdata_o, 32'h0000_00A5);
            chk("st_wen",   tcdm.data_wen_o, 0);
            if (i == 4) begin
                tcdm.data_gnt_i = 1'b1;
                LSU_En = 1'b0;
            end
            step();
        end
        tcdm.data_gnt_i = 1'b0;
        chk("st_wait_req",  tcdm.data_req_o, 0);
        chk("st_wait_busy", lsu_busy_o, 1);
        tcdm.data_r_valid_i = 1'b1;
        tcdm.data_r_rdata_i = 32'h1234_5678;
        step();
        tcdm.data_r_valid_i = 1'b0;
        chk("st_no_pulse", data_req_valid_o, 0);
        chk("st_ld_kept",  load_data_o, 32'hDEAD_BEEF);
        chk("st_busy_off", lsu_busy_o, 0);
        chk("st_no_err",   protocol_err_o, 0);
        step();

        // Back-to-back loads, second start in the pulse cycle
        do_load(32'h0000_0100, 32'h11);
        chk("b2b_first", load_data_o, 32'h11);
        do_load(32'h0000_0104, 32'h22);
        chk("b2b_second", load_data_o, 32'h22);
        step();
        chk("b2b_idle", data_req_valid_o, 0);

        // Exec_En_Global dropped while in WAIT
        exp_q.push_back(32'h33);
        issue(5'b00111, 32'h0000_0200, '0);
        step();
        LSU_En = 1'b0;
        tcdm.data_gnt_i = 1'b1;
        step();
        tcdm.data_gnt_i = 1'b0;
        Exec_En_Global  = 1'b0;
        step();
        chk("ex_still_busy", lsu_busy_o, 1);
        tcdm.data_r_valid_i = 1'b1;
        tcdm.data_r_rdata_i = 32'h33;
        step();
        tcdm.data_r_valid_i = 1'b0;
        chk("ex_pulse", data_req_valid_o, 1);
        issue(5'b00111, 32'h0000_0300, '0);
        step();
        chk("ex_blocked_req",  tcdm.data_req_o, 0);
        chk("ex_blocked_busy", lsu_busy_o, 0);
        LSU_En = 1'b0;
        Exec_En_Global = 1'b1;
        step();

        // Reset asserted during REQ
        issue(5'b00111, 32'h0000_0400, '0);
        step();
        LSU_En = 1'b0;
        chk("rr_req_before", tcdm.data_req_o, 1);
        #2;
        Reset = 1'b0;
        #1;
        chk("rr_req_async", tcdm.data_req_o, 0);
        chk("rr_add",       tcdm.data_add_o, 0);
        chk("rr_wen",       tcdm.data_wen_o, 1);
        chk("rr_busy",      lsu_busy_o, 0);
        chk("rr_ld",        load_data_o, 0);
        chk("rr_vld",       data_req_valid_o, 0);
        tcdm.data_gnt_i = 1'b1;
        step();
        tcdm.data_gnt_i = 1'b0;
        Reset = 1'b1;
        step();
        chk("rr_no_pulse", data_req_valid_o, 0);
        do_load(32'h0000_0500, 32'h44);
        step();

        // Stray r_valid in IDLE
        tcdm.data_r_valid_i = 1'b1;
        tcdm.data_r_rdata_i = 32'h0000_0BAD;
        step();
        tcdm.data_r_valid_i = 1'b0;
        chk("pe_err_set",   protocol_err_o, 1);
        chk("pe_no_pulse",  data_req_valid_o, 0);
        chk("pe_ld_intact", load_data_o, 32'h44);
        do_load(32'h0000_0600, 32'h55);
        step();
        chk("pe_err_sticky", protocol_err_o, 1);
        chk("pe_ld_after",   load_data_o, 32'h55);

        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
